// File: rtl/cmp_share_arb.sv
// Purpose: one shared DW-bit ">= threshold" comparator, time-multiplexed round-robin across N_REQ requesters.
// Latency: grant one cycle after a request is seen in IDLE, tagged result one cycle after the grant, 3 cycles/compare.
// Backpressure: requests hold req_i until gnt_o; requests arriving while busy_o=1 wait until IDLE.
module cmp_share_arb #(
    parameter int          N_REQ      = 4,
    parameter int          DW         = 8,
    parameter int          IDW        = 2,
    parameter int unsigned DEF_THRESH = 10
) (
    input  logic                clk_a,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] data_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic                rsp_valid_o,
    output logic [IDW-1:0]      rsp_id_o,
    output logic                rsp_ge_o,
    output logic                busy_o,
    input  logic                cfg_we_i,
    input  logic [IDW-1:0]      cfg_id_i,
    input  logic [DW-1:0]       cfg_thresh_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [DW-1:0]      smp_q, smp_d;
    logic [DW-1:0]      thresh_q [N_REQ];
    logic [DW-1:0]      thresh_d [N_REQ];
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_ge_q, rsp_ge_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [DW-1:0]      win_smp;
    logic [DW-1:0]      cur_thr;

    // Round-robin pick: first set request scanning upward from ptr, wrapping at N_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!win_found && req_i[k] &&
                    ((int'(ptr_q) + i == k) || (int'(ptr_q) + i - N_REQ == k))) begin
                    win_found = 1'b1;
                    win_id    = IDW'(k);
                end
            end
        end
    end

    // Operand muxes: winner's sample slice and the captured requester's threshold.
    always_comb begin
        win_smp = '0;
        cur_thr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == IDW'(k)) win_smp = data_i[k*DW +: DW];
            if (id_q == IDW'(k))   cur_thr = thresh_q[k];
        end
    end

    // Next-state, threshold writes and registered outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        smp_d       = smp_q;
        rsp_id_d    = rsp_id_q;
        rsp_ge_d    = rsp_ge_q;
        gnt_d       = '0;
        rsp_valid_d = 1'b0;
        thresh_d    = thresh_q;

        // Indices >= N_REQ match no slot and are dropped. The compare below reads
        // thresh_q, so a write landing in the CMP cycle only affects later compares.
        for (int k = 0; k < N_REQ; k++) begin
            if (cfg_we_i && (cfg_id_i == IDW'(k))) thresh_d[k] = cfg_thresh_i;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    id_d  = win_id;
                    smp_d = win_smp;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (win_id == IDW'(k)) gnt_d[k] = 1'b1;
                    end
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                rsp_ge_d    = (smp_q >= cur_thr);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops any in-flight compare.
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            smp_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ge_q    <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < N_REQ; k++) thresh_q[k] <= DW'(DEF_THRESH);
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            smp_q       <= smp_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ge_q    <= rsp_ge_d;
            busy_q      <= busy_d;
            for (int k = 0; k < N_REQ; k++) thresh_q[k] <= thresh_d[k];
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_ge_o    = rsp_ge_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb: a default 4-requester instance plus a 3-requester
// instance for out-of-range configuration writes.
// Inputs are driven 1ns after the rising edge, outputs sampled at the same point.
module tb_cmp_share_arb;

    logic        clk_a = 1'b0;
    logic        rst   = 1'b1;

    logic [3:0]  req     = '0;
    logic [31:0] data    = '0;
    logic        cfg_we  = 1'b0;
    logic [1:0]  cfg_id  = '0;
    logic [7:0]  cfg_thr = '0;
    logic [3:0]  gnt;
    logic        rsp_valid, rsp_ge, busy;
    logic [1:0]  rsp_id;

    logic [2:0]  req3     = '0;
    logic [23:0] data3    = '0;
    logic        cfg_we3  = 1'b0;
    logic [1:0]  cfg_id3  = '0;
    logic [7:0]  cfg_thr3 = '0;
    logic [2:0]  gnt3;
    logic        rsp_valid3, rsp_ge3, busy3;
    logic [1:0]  rsp_id3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk_a = ~clk_a;
    always @(posedge clk_a) cyc <= cyc + 1;

    cmp_share_arb u_dut (
        .clk_a(clk_a), .rst(rst), .req_i(req), .data_i(data), .gnt_o(gnt),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_ge_o(rsp_ge), .busy_o(busy),
        .cfg_we_i(cfg_we), .cfg_id_i(cfg_id), .cfg_thresh_i(cfg_thr)
    );

    cmp_share_arb #(.N_REQ(3)) u_dut3 (
        .clk_a(clk_a), .rst(rst), .req_i(req3), .data_i(data3), .gnt_o(gnt3),
        .rsp_valid_o(rsp_valid3), .rsp_id_o(rsp_id3), .rsp_ge_o(rsp_ge3), .busy_o(busy3),
        .cfg_we_i(cfg_we3), .cfg_id_i(cfg_id3), .cfg_thresh_i(cfg_thr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cfg_write(input int id, input logic [7:0] val);
        cfg_we  = 1'b1;
        cfg_id  = id[1:0];
        cfg_thr = val;
        tick();
        cfg_we  = 1'b0;
    endtask

    // One full request/grant/response on the 4-requester instance.
    task automatic do_cmp(input int k, input logic [7:0] s, input logic exp_ge, input string tag);
        bit ok;
        req[k]         = 1'b1;
        data[k*8 +: 8] = s;
        wait_gnt(ok);
        check({tag, "_gnt_seen"}, 32'(ok), 1);
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
        check({tag, "_busy"}, 32'(busy), 1);
        req[k] = 1'b0;
        tick();
        check({tag, "_vld"}, 32'(rsp_valid), 1);
        check({tag, "_id"}, 32'(rsp_id), 32'(k));
        check({tag, "_ge"}, 32'(rsp_ge), 32'(exp_ge));
        tick();
        check({tag, "_vld_off"}, 32'(rsp_valid), 0);
        check({tag, "_id_hold"}, 32'(rsp_id), 32'(k));
        check({tag, "_ge_hold"}, 32'(rsp_ge), 32'(exp_ge));
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic do_cmp3(input int k, input logic [7:0] s, input logic exp_ge, input string tag);
        bit ok;
        req3[k]         = 1'b1;
        data3[k*8 +: 8] = s;
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (gnt3 != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_gnt_seen"}, 32'(ok), 1);
        check({tag, "_gnt"}, 32'(gnt3), 32'(1 << k));
        req3[k] = 1'b0;
        tick();
        check({tag, "_vld"}, 32'(rsp_valid3), 1);
        check({tag, "_id"}, 32'(rsp_id3), 32'(k));
        check({tag, "_ge"}, 32'(rsp_ge3), 32'(exp_ge));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        int          last_cyc;
        logic [3:0]  gv;

        // Reset values
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_vld", 32'(rsp_valid), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_ge", 32'(rsp_ge), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Default threshold 10: equality passes, one below fails
        do_cmp(0, 8'd10, 1'b1, "def_eq");
        do_cmp(0, 8'd9,  1'b0, "def_lt");

        // Round-robin under continuous requests, ptr from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        data     = {4{8'd100}};
        req      = 4'hF;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(ok);
            check($sformatf("rr%0d_seen", g), 32'(ok), 1);
            check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(1 << exp_order[g]));
            if (g > 0) check($sformatf("rr%0d_space", g), 32'(cyc - last_cyc), 3);
            last_cyc = cyc;
            gv  = gnt;
            req = req & ~gv;
            tick();
            check($sformatf("rr%0d_vld", g), 32'(rsp_valid), 1);
            check($sformatf("rr%0d_id", g), 32'(rsp_id), 32'(exp_order[g]));
            check($sformatf("rr%0d_ge", g), 32'(rsp_ge), 1);
            req = req | gv;
        end
        req = '0;
        tick();

        // Programmed thresholds on requester 2 and their boundaries
        cfg_write(2, 8'd200);
        do_cmp(2, 8'd199, 1'b0, "t200_199");
        do_cmp(2, 8'd200, 1'b1, "t200_200");
        do_cmp(2, 8'd255, 1'b1, "t200_255");
        cfg_write(2, 8'd0);
        do_cmp(2, 8'd0, 1'b1, "t0_0");
        cfg_write(2, 8'd255);
        do_cmp(2, 8'd254, 1'b0, "t255_254");
        do_cmp(2, 8'd255, 1'b1, "t255_255");

        // Write threshold[1]=50 during requester 1's CMP cycle: old threshold 10 applies
        req[1]       = 1'b1;
        data[15:8]   = 8'd20;
        wait_gnt(ok);
        check("wr_cmp_seen", 32'(ok), 1);
        check("wr_cmp_gnt", 32'(gnt), 32'h2);
        req[1]  = 1'b0;
        cfg_we  = 1'b1;
        cfg_id  = 2'd1;
        cfg_thr = 8'd50;
        tick();
        cfg_we = 1'b0;
        check("wr_cmp_vld", 32'(rsp_valid), 1);
        check("wr_cmp_ge_old", 32'(rsp_ge), 1);
        tick();
        do_cmp(1, 8'd20, 1'b0, "wr_cmp_new");

        // Reset during CMP (ptr is 2 at this point)
        req[0]    = 1'b1;
        data[7:0] = 8'd50;
        wait_gnt(ok);
        check("rstc_seen", 32'(ok), 1);
        req[0] = 1'b0;
        rst    = 1'b1;
        #1;
        check("rstc_gnt", 32'(gnt), 0);
        check("rstc_vld", 32'(rsp_valid), 0);
        check("rstc_id", 32'(rsp_id), 0);
        check("rstc_ge", 32'(rsp_ge), 0);
        check("rstc_busy", 32'(busy), 0);
        tick();
        check("rstc_vld_hold", 32'(rsp_valid), 0);
        rst = 1'b0;
        tick();
        check("rstc_vld_after", 32'(rsp_valid), 0);
        check("rstc_busy_after", 32'(busy), 0);
        // ptr back at 0 picks requester 1 over 2; threshold[1] back at 10 gives ge=1 for 20
        req        = 4'b0110;
        data[15:8] = 8'd20;
        data[23:16] = 8'd20;
        wait_gnt(ok);
        check("rstp_seen", 32'(ok), 1);
        check("rstp_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("rstp_id", 32'(rsp_id), 1);
        check("rstp_ge", 32'(rsp_ge), 1);
        tick();
        do_cmp(3, 8'd7, 1'b0, "rst_r3");

        // 3-requester instance: a write to index 3 must change nothing
        cfg_we3  = 1'b1;
        cfg_id3  = 2'd3;
        cfg_thr3 = 8'd200;
        tick();
        cfg_we3 = 1'b0;
        for (int k = 0; k < 3; k++) do_cmp3(k, 8'd10, 1'b1, $sformatf("n3_oob_r%0d", k));
        cfg_we3  = 1'b1;
        cfg_id3  = 2'd2;
        cfg_thr3 = 8'd11;
        tick();
        cfg_we3 = 1'b0;
        do_cmp3(2, 8'd10, 1'b0, "n3_valid_wr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
